// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_add_pkg

// File: rtl/serial_add_seq_if.sv
// Start/done request bus of the serial adder. The master issues operands, the
// slave (the adder) returns status, result and a debug view of its FSM state.
interface serial_add_seq_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    // Handshake: start is honoured only on an edge where busy is low; a, b and
    // cin are sampled on that same edge. done pulses for one cycle when
    // sum/cout are newly valid; sum/cout hold until the next completion.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    state_t           dbg_state;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, dbg_state
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, dbg_state
    );

endinterface : serial_add_seq_if

// File: rtl/serial_add_seq_fulladd.sv
// Library one-bit full adder cell.
module fulladd (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule : fulladd

// File: rtl/serial_add_seq.sv
// Bit-serial LSB-first adder: one full-adder cell plus a registered carry,
// WIDTH shift cycles per operation, one-cycle done pulse on completion.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    serial_add_seq_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_s;
    logic fa_co;
    logic accept;
    logic last_bit;

    assign accept   = (state_q == IDLE) && bus.start;
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    fulladd u_fa (
        .a_i  (areg_q[0]),
        .b_i  (breg_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_ff @(posedge clk or posedge reset) begin : state_reg
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
        bus.dbg_state = state_q;
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    always_comb begin : datapath
        areg_d  = areg_q;
        breg_d  = breg_q;
        sreg_d  = sreg_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            areg_d  = bus.a;
            breg_d  = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
            sreg_d  = '0;
        end else if (state_q == SHIFT) begin
            // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            sreg_d  = {fa_s, sreg_q[WIDTH-1:1]};
            areg_d  = {1'b0, areg_q[WIDTH-1:1]};
            breg_d  = {1'b0, breg_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            if (last_bit) begin
                sum_d  = {fa_s, sreg_q[WIDTH-1:1]};
                cout_d = fa_co;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin : datapath_reg
        if (reset) begin
            areg_q  <= '0;
            breg_q  <= '0;
            sreg_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            sreg_q  <= sreg_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : serial_add_seq
